// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex receive path: FSM states, ASCII hex
// range limits and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } rx_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  // 50 MHz / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex character decoder: '0'-'9', 'A'-'F', 'a'-'f'
// map to 0-15 with valid=1; anything else gives valid=0 and value=0.
module ascii_hex_decode
  import uart_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] value,
  output logic       valid
);

  always_comb begin
    value = '0;
    valid = 1'b0;
    if (ch >= ASCII_0 && ch <= ASCII_9) begin
      value = ch[3:0];
      valid = 1'b1;
    end else if ((ch >= ASCII_UA && ch <= ASCII_UF) ||
                 (ch >= ASCII_LA && ch <= ASCII_LF)) begin
      // Letters A-F/a-f have low nibble 1..6, so adding 9 yields 10..15.
      value = ch[3:0] + 4'd9;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/uart_hex_rx.sv
// 8N1 UART receiver that decodes ASCII hex characters into nibbles, with a
// one-cycle rx_dv pulse per valid character and rx_err on bad frames/chars.
module uart_hex_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [3:0] rx_nibble,
  output logic       rx_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  // The IDLE cycle that sees the start edge counts as cycle 0 of the start
  // bit, so the counter (cleared there) reaches H-1 at t0+H.
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2 - 1);

  logic [1:0]    sync_q;
  logic          rxs;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          armed;
  logic [3:0]    dec_value;
  logic          dec_valid;

  assign rxs = sync_q[1];

  ascii_hex_decode u_decode (
    .ch    (shreg),
    .value (dec_value),
    .valid (dec_valid)
  );

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync_q    <= '1;
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      bit_idx   <= '0;
      armed     <= 1'b0;
      rx_dv     <= 1'b0;
      rx_err    <= 1'b0;
      rx_nibble <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
      rx_dv  <= 1'b0;
      rx_err <= 1'b0;
      if (rxs) armed <= 1'b1;

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (armed && !rxs) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= CLEANUP;
            if (rxs) begin
              if (dec_valid) begin
                rx_dv     <= 1'b1;
                rx_nibble <= dec_value;
              end else begin
                rx_err <= 1'b1;
              end
            end else begin
              // Disarm so a held-low line (break) cannot start a new frame.
              rx_err <= 1'b1;
              armed  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEANUP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_rx.sv
// Directed bench for uart_hex_rx with CLKS_PER_BIT=8 (H=3); pulses are
// timestamped relative to the start-bit drive cycle E (expected at E+78).
module tb_uart_hex_rx;
  import uart_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned LAT = 78;

  logic       clk;
  logic       rst;
  logic       rx_serial;
  logic       rx_dv;
  logic [3:0] rx_nibble;
  logic       rx_err;

  int unsigned cyc;
  int unsigned vec;
  int unsigned miscmp;
  int unsigned both_cnt;
  int unsigned dv_cyc_q[$];
  logic [3:0]  dv_nib_q[$];
  int unsigned err_cyc_q[$];

  uart_hex_rx #(.CLKS_PER_BIT(N)) dut (
    .CLOCK_50  (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .rx_dv     (rx_dv),
    .rx_nibble (rx_nibble),
    .rx_err    (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rx_dv) begin
      dv_cyc_q.push_back(cyc);
      dv_nib_q.push_back(rx_nibble);
    end
    if (rx_err) err_cyc_q.push_back(cyc);
    if (rx_dv && rx_err) both_cnt = both_cnt + 1;
  end

  task automatic clear_mon();
    dv_cyc_q.delete();
    dv_nib_q.delete();
    err_cyc_q.delete();
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, output int unsigned e);
    e = cyc;
    rx_serial = 1'b0;
    wait_cycles(N);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      wait_cycles(N);
    end
    rx_serial = stop_v;
    wait_cycles(N);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_serial = 1'b1;
    wait_cycles(4);
    vec++; if (rx_dv !== 1'b0) begin miscmp++; $display("FAIL reset_dv: got %b want 0", rx_dv); end
    vec++; if (rx_err !== 1'b0) begin miscmp++; $display("FAIL reset_err: got %b want 0", rx_err); end
    vec++; if (rx_nibble !== 4'h0) begin miscmp++; $display("FAIL reset_nibble: got %h want 0", rx_nibble); end
    rst = 1'b0;
    wait_cycles(8);
  endtask

  task automatic test_single();
    int unsigned e;
    clear_mon();
    send_byte(8'h37, 1'b1, e);
    wait_cycles(10);
    vec++; if (dv_cyc_q.size() !== 1) begin miscmp++; $display("FAIL single_dv_count: got %0d want 1", dv_cyc_q.size()); end
    if (dv_cyc_q.size() >= 1) begin
      vec++; if (dv_cyc_q[0] !== e + LAT) begin miscmp++; $display("FAIL single_dv_time: got %0d want %0d", dv_cyc_q[0], e + LAT); end
      vec++; if (dv_nib_q[0] !== 4'h7) begin miscmp++; $display("FAIL single_nibble: got %h want 7", dv_nib_q[0]); end
    end
    vec++; if (err_cyc_q.size() !== 0) begin miscmp++; $display("FAIL single_err: got %0d want 0", err_cyc_q.size()); end
    vec++; if (rx_nibble !== 4'h7) begin miscmp++; $display("FAIL single_hold: got %h want 7", rx_nibble); end
  endtask

  task automatic test_back_to_back();
    int unsigned e1, e2;
    clear_mon();
    send_byte(8'h61, 1'b1, e1);
    send_byte(8'h46, 1'b1, e2);
    wait_cycles(10);
    vec++; if (dv_cyc_q.size() !== 2) begin miscmp++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cyc_q.size()); end
    if (dv_cyc_q.size() == 2) begin
      vec++; if (dv_cyc_q[0] !== e1 + LAT) begin miscmp++; $display("FAIL b2b_first_time: got %0d want %0d", dv_cyc_q[0], e1 + LAT); end
      vec++; if (dv_cyc_q[1] - dv_cyc_q[0] !== 80) begin miscmp++; $display("FAIL b2b_spacing: got %0d want 80", dv_cyc_q[1] - dv_cyc_q[0]); end
      vec++; if (dv_nib_q[0] !== 4'hA) begin miscmp++; $display("FAIL b2b_nib_a: got %h want a", dv_nib_q[0]); end
      vec++; if (dv_nib_q[1] !== 4'hF) begin miscmp++; $display("FAIL b2b_nib_f: got %h want f", dv_nib_q[1]); end
    end
    vec++; if (err_cyc_q.size() !== 0) begin miscmp++; $display("FAIL b2b_err: got %0d want 0", err_cyc_q.size()); end
  endtask

  task automatic test_non_hex();
    int unsigned e;
    clear_mon();
    send_byte(8'h47, 1'b1, e);
    wait_cycles(10);
    vec++; if (err_cyc_q.size() !== 1) begin miscmp++; $display("FAIL nonhex_err_count: got %0d want 1", err_cyc_q.size()); end
    if (err_cyc_q.size() >= 1) begin
      vec++; if (err_cyc_q[0] !== e + LAT) begin miscmp++; $display("FAIL nonhex_err_time: got %0d want %0d", err_cyc_q[0], e + LAT); end
    end
    vec++; if (dv_cyc_q.size() !== 0) begin miscmp++; $display("FAIL nonhex_dv: got %0d want 0", dv_cyc_q.size()); end
    vec++; if (rx_nibble !== 4'hF) begin miscmp++; $display("FAIL nonhex_hold: got %h want f", rx_nibble); end
  endtask

  task automatic test_framing();
    int unsigned e;
    clear_mon();
    send_byte(8'h35, 1'b0, e);
    wait_cycles(200);
    vec++; if (err_cyc_q.size() !== 1) begin miscmp++; $display("FAIL frame_err_count: got %0d want 1", err_cyc_q.size()); end
    if (err_cyc_q.size() >= 1) begin
      vec++; if (err_cyc_q[0] !== e + LAT) begin miscmp++; $display("FAIL frame_err_time: got %0d want %0d", err_cyc_q[0], e + LAT); end
    end
    vec++; if (dv_cyc_q.size() !== 0) begin miscmp++; $display("FAIL frame_dv: got %0d want 0", dv_cyc_q.size()); end
    vec++; if (rx_nibble !== 4'hF) begin miscmp++; $display("FAIL frame_hold: got %h want f", rx_nibble); end
    rx_serial = 1'b1;
    wait_cycles(16);
    clear_mon();
    send_byte(8'h32, 1'b1, e);
    wait_cycles(10);
    vec++; if (dv_cyc_q.size() !== 1) begin miscmp++; $display("FAIL frame_recover_dv: got %0d want 1", dv_cyc_q.size()); end
    vec++; if (rx_nibble !== 4'h2) begin miscmp++; $display("FAIL frame_recover_nib: got %h want 2", rx_nibble); end
    vec++; if (err_cyc_q.size() !== 0) begin miscmp++; $display("FAIL frame_recover_err: got %0d want 0", err_cyc_q.size()); end
  endtask

  task automatic test_glitch();
    int unsigned e;
    clear_mon();
    rx_serial = 1'b0;
    wait_cycles(2);
    rx_serial = 1'b1;
    wait_cycles(20);
    vec++; if (dv_cyc_q.size() + err_cyc_q.size() !== 0) begin miscmp++; $display("FAIL glitch_pulses: got %0d want 0", dv_cyc_q.size() + err_cyc_q.size()); end
    vec++; if (dut.state !== IDLE) begin miscmp++; $display("FAIL glitch_state: got %0d want %0d", dut.state, IDLE); end
    send_byte(8'h39, 1'b1, e);
    wait_cycles(10);
    vec++; if (dv_cyc_q.size() !== 1) begin miscmp++; $display("FAIL glitch_next_dv: got %0d want 1", dv_cyc_q.size()); end
    vec++; if (rx_nibble !== 4'h9) begin miscmp++; $display("FAIL glitch_next_nib: got %h want 9", rx_nibble); end
  endtask

  task automatic test_reset_mid();
    int unsigned e;
    logic [7:0] b;
    b = 8'h33;
    clear_mon();
    rx_serial = 1'b0;
    wait_cycles(N);
    for (int i = 0; i < 4; i++) begin
      rx_serial = b[i];
      wait_cycles(N);
    end
    rx_serial = b[4];
    wait_cycles(N / 2);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    rx_serial = 1'b1;
    wait_cycles(100);
    vec++; if (dv_cyc_q.size() + err_cyc_q.size() !== 0) begin miscmp++; $display("FAIL rstmid_pulses: got %0d want 0", dv_cyc_q.size() + err_cyc_q.size()); end
    vec++; if (rx_nibble !== 4'h0) begin miscmp++; $display("FAIL rstmid_nibble: got %h want 0", rx_nibble); end
    send_byte(8'h39, 1'b1, e);
    wait_cycles(10);
    vec++; if (dv_cyc_q.size() !== 1) begin miscmp++; $display("FAIL rstmid_next_dv: got %0d want 1", dv_cyc_q.size()); end
    if (dv_cyc_q.size() >= 1) begin
      vec++; if (dv_cyc_q[0] !== e + LAT) begin miscmp++; $display("FAIL rstmid_next_time: got %0d want %0d", dv_cyc_q[0], e + LAT); end
    end
    vec++; if (rx_nibble !== 4'h9) begin miscmp++; $display("FAIL rstmid_next_nib: got %h want 9", rx_nibble); end
  endtask

  initial begin
    cyc = 0;
    vec = 0;
    miscmp = 0;
    both_cnt = 0;
    rst = 1'b1;
    rx_serial = 1'b1;
    wait_cycles(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_non_hex();
    test_framing();
    test_glitch();
    test_reset_mid();
    vec++; if (both_cnt !== 0) begin miscmp++; $display("FAIL dv_err_overlap: got %0d want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
